// File: rtl/control_unit.sv
// rtl/control_unit.sv - hardwired T0..T5 sequencer and instruction decoder for the cpu datapath
// Optional feature: define CONTROL_FPU_EN to decode opcode 1B as an FPU instruction.
module control_unit (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir_out,
  input  logic        branch_condition,
  output logic        ir_en,
  output logic        pc_increment,
  output logic        pc_in_alu,
  output logic        pc_in_rf_a,
  output logic        ma_in_pc,
  output logic        ma_in_alu,
  output logic        alu_a_in_rf,
  output logic        alu_a_in_pc,
  output logic        alu_b_in_rf,
  output logic        alu_b_in_constant,
  output logic        lo_en,
  output logic        hi_en,
  output logic        rf_in_alu,
  output logic        rf_in_hi,
  output logic        rf_in_lo,
  output logic        rf_in_memory,
  output logic        rf_in_fpu,
  output logic        memory_en,
  output logic [11:0] alu_select,
  output logic [11:0] fpu_select,
  output logic        fpu_mode,
  output logic        run,
  output logic        illegal
);

  // Opcode map (ir_out[31:27])
  localparam logic [4:0] OP_LD   = 5'h00;
  localparam logic [4:0] OP_LDI  = 5'h01;
  localparam logic [4:0] OP_ST   = 5'h02;
  localparam logic [4:0] OP_ADD  = 5'h03;
  localparam logic [4:0] OP_SUB  = 5'h04;
  localparam logic [4:0] OP_SHR  = 5'h05;
  localparam logic [4:0] OP_SHL  = 5'h06;
  localparam logic [4:0] OP_ROR  = 5'h07;
  localparam logic [4:0] OP_ROL  = 5'h08;
  localparam logic [4:0] OP_AND  = 5'h09;
  localparam logic [4:0] OP_OR   = 5'h0A;
  localparam logic [4:0] OP_ADDI = 5'h0B;
  localparam logic [4:0] OP_ANDI = 5'h0C;
  localparam logic [4:0] OP_ORI  = 5'h0D;
  localparam logic [4:0] OP_MUL  = 5'h0E;
  localparam logic [4:0] OP_DIV  = 5'h0F;
  localparam logic [4:0] OP_NEG  = 5'h10;
  localparam logic [4:0] OP_NOT  = 5'h11;
  localparam logic [4:0] OP_BR   = 5'h12;
  localparam logic [4:0] OP_JR   = 5'h13;
  localparam logic [4:0] OP_JAL  = 5'h14;
  localparam logic [4:0] OP_MFHI = 5'h17;
  localparam logic [4:0] OP_MFLO = 5'h18;
  localparam logic [4:0] OP_NOP  = 5'h19;
  localparam logic [4:0] OP_HALT = 5'h1A;
`ifdef CONTROL_FPU_EN
  localparam logic [4:0] OP_FPU  = 5'h1B;
`endif

  // One-hot ALU operations, bit order {not,neg,div,mul,or,and,rol,ror,shl,shr,sub,add}
  localparam logic [11:0] ALU_ADD = 12'h001;
  localparam logic [11:0] ALU_SUB = 12'h002;
  localparam logic [11:0] ALU_SHR = 12'h004;
  localparam logic [11:0] ALU_SHL = 12'h008;
  localparam logic [11:0] ALU_ROR = 12'h010;
  localparam logic [11:0] ALU_ROL = 12'h020;
  localparam logic [11:0] ALU_AND = 12'h040;
  localparam logic [11:0] ALU_OR  = 12'h080;
  localparam logic [11:0] ALU_MUL = 12'h100;
  localparam logic [11:0] ALU_DIV = 12'h200;
  localparam logic [11:0] ALU_NEG = 12'h400;
  localparam logic [11:0] ALU_NOT = 12'h800;

  typedef enum logic [2:0] {
    T0   = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    T3   = 3'd3,
    T4   = 3'd4,
    T5   = 3'd5,
    HALT = 3'd6
  } state_t;

  state_t state, next_state;

  logic [4:0]  opcode;
  logic [11:0] alu_op;
  logic        is_reg_alu;   // rf op rf -> rf
  logic        is_imm_alu;   // rf op constant -> rf
  logic        is_muldiv;    // rf op rf -> HI/LO
  logic        is_mfhi;
  logic        is_mflo;
  logic        is_ld;
  logic        is_st;
  logic        is_br;
  logic        is_jr;
  logic        is_jal;
  logic        is_halt;
  logic        is_illegal;

  assign opcode = ir_out[31:27];

`ifdef CONTROL_FPU_EN
  logic [3:0]  fpu_fn;
  logic        is_fpu;
  logic [11:0] fpu_op;
  logic        unused_ir;

  assign fpu_fn    = ir_out[3:0];
  assign fpu_op    = 12'b1 << fpu_fn;
  assign unused_ir = ^ir_out[26:4];
`else
  logic        unused_ir;

  assign unused_ir = ^ir_out[26:0];
`endif

  // Instruction decode: classify the opcode and pick the ALU operation
  always_comb begin
    alu_op     = 12'h000;
    is_reg_alu = 1'b0;
    is_imm_alu = 1'b0;
    is_muldiv  = 1'b0;
    is_mfhi    = 1'b0;
    is_mflo    = 1'b0;
    is_ld      = 1'b0;
    is_st      = 1'b0;
    is_br      = 1'b0;
    is_jr      = 1'b0;
    is_jal     = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
`ifdef CONTROL_FPU_EN
    is_fpu     = 1'b0;
`endif
    case (opcode)
      OP_LD:   begin is_ld = 1'b1;      alu_op = ALU_ADD; end
      OP_LDI:  begin is_imm_alu = 1'b1; alu_op = ALU_ADD; end
      OP_ST:   begin is_st = 1'b1;      alu_op = ALU_ADD; end
      OP_ADD:  begin is_reg_alu = 1'b1; alu_op = ALU_ADD; end
      OP_SUB:  begin is_reg_alu = 1'b1; alu_op = ALU_SUB; end
      OP_SHR:  begin is_reg_alu = 1'b1; alu_op = ALU_SHR; end
      OP_SHL:  begin is_reg_alu = 1'b1; alu_op = ALU_SHL; end
      OP_ROR:  begin is_reg_alu = 1'b1; alu_op = ALU_ROR; end
      OP_ROL:  begin is_reg_alu = 1'b1; alu_op = ALU_ROL; end
      OP_AND:  begin is_reg_alu = 1'b1; alu_op = ALU_AND; end
      OP_OR:   begin is_reg_alu = 1'b1; alu_op = ALU_OR;  end
      OP_ADDI: begin is_imm_alu = 1'b1; alu_op = ALU_ADD; end
      OP_ANDI: begin is_imm_alu = 1'b1; alu_op = ALU_AND; end
      OP_ORI:  begin is_imm_alu = 1'b1; alu_op = ALU_OR;  end
      OP_MUL:  begin is_muldiv = 1'b1;  alu_op = ALU_MUL; end
      OP_DIV:  begin is_muldiv = 1'b1;  alu_op = ALU_DIV; end
      OP_NEG:  begin is_reg_alu = 1'b1; alu_op = ALU_NEG; end
      OP_NOT:  begin is_reg_alu = 1'b1; alu_op = ALU_NOT; end
      OP_BR:   begin is_br = 1'b1;      alu_op = ALU_ADD; end
      OP_JR:   is_jr = 1'b1;
      OP_JAL:  begin is_jal = 1'b1;     alu_op = ALU_ADD; end
      OP_MFHI: is_mfhi = 1'b1;
      OP_MFLO: is_mflo = 1'b1;
      OP_NOP:  ;
      OP_HALT: is_halt = 1'b1;
`ifdef CONTROL_FPU_EN
      OP_FPU: begin
        // Only function codes 0..11 name an FPU operation
        if (fpu_fn < 4'd12) is_fpu = 1'b1;
        else                is_illegal = 1'b1;
      end
`endif
      default: is_illegal = 1'b1;
    endcase
  end

  // State register and sticky illegal-opcode flag
  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= T0;
      illegal <= 1'b0;
    end else begin
      state <= next_state;
      if (state == T3 && is_illegal) illegal <= 1'b1;
    end
  end

  // Next-state: fetch T0..T2, then execute length depends on the opcode
  always_comb begin
    next_state = T0;
    case (state)
      T0: next_state = T1;
      T1: next_state = T2;
      T2: next_state = T3;
      T3: begin
        if (is_halt)                        next_state = HALT;
        else if (is_ld || is_st || is_jal)  next_state = T4;
        else                                next_state = T0;
      end
      T4:      next_state = is_ld ? T5 : T0;
      T5:      next_state = T0;
      HALT:    next_state = HALT;
      default: next_state = T0;
    endcase
  end

  // Control outputs: decode of the current state and opcode, forced low while clr is high
  always_comb begin
    ir_en             = 1'b0;
    pc_increment      = 1'b0;
    pc_in_alu         = 1'b0;
    pc_in_rf_a        = 1'b0;
    ma_in_pc          = 1'b0;
    ma_in_alu         = 1'b0;
    alu_a_in_rf       = 1'b0;
    alu_a_in_pc       = 1'b0;
    alu_b_in_rf       = 1'b0;
    alu_b_in_constant = 1'b0;
    lo_en             = 1'b0;
    hi_en             = 1'b0;
    rf_in_alu         = 1'b0;
    rf_in_hi          = 1'b0;
    rf_in_lo          = 1'b0;
    rf_in_memory      = 1'b0;
    rf_in_fpu         = 1'b0;
    memory_en         = 1'b0;
    alu_select        = 12'h000;
    fpu_select        = 12'h000;
    fpu_mode          = 1'b0;
    if (!clr) begin
      case (state)
        T0: begin
          pc_increment = 1'b1;
          ma_in_pc     = 1'b1;
        end
        T2: ir_en = 1'b1;
        T3: begin
          if (is_reg_alu) begin
            alu_a_in_rf = 1'b1;
            alu_b_in_rf = 1'b1;
            rf_in_alu   = 1'b1;
            alu_select  = alu_op;
          end
          if (is_imm_alu) begin
            alu_a_in_rf       = 1'b1;
            alu_b_in_constant = 1'b1;
            rf_in_alu         = 1'b1;
            alu_select        = alu_op;
          end
          if (is_muldiv) begin
            alu_a_in_rf = 1'b1;
            alu_b_in_rf = 1'b1;
            alu_select  = alu_op;
            lo_en       = 1'b1;
            hi_en       = 1'b1;
          end
          if (is_mfhi) rf_in_hi = 1'b1;
          if (is_mflo) rf_in_lo = 1'b1;
          // Loads and stores both form the effective address in MA
          if (is_ld || is_st) begin
            alu_a_in_rf       = 1'b1;
            alu_b_in_constant = 1'b1;
            alu_select        = alu_op;
            ma_in_alu         = 1'b1;
          end
          if (is_br) begin
            alu_a_in_pc       = 1'b1;
            alu_b_in_constant = 1'b1;
            alu_select        = alu_op;
            pc_in_alu         = branch_condition;
          end
          if (is_jr) pc_in_rf_a = 1'b1;
          // jal writes PC+0 (the link) to the register file before jumping in T4
          if (is_jal) begin
            alu_a_in_pc       = 1'b1;
            alu_b_in_constant = 1'b1;
            alu_select        = alu_op;
            rf_in_alu         = 1'b1;
          end
`ifdef CONTROL_FPU_EN
          if (is_fpu) begin
            fpu_mode   = 1'b1;
            fpu_select = fpu_op;
          end
`endif
        end
        T4: begin
          if (is_st)  memory_en  = 1'b1;
          if (is_jal) pc_in_rf_a = 1'b1;
        end
        T5: begin
          if (is_ld) rf_in_memory = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign run = (state != HALT);

endmodule
